// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and constants for the serial pattern detector sequencer.
// State encoding, default widths and the bit-index width helper.
package seq_det_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    // Width of a bit index within a word, never narrower than one bit.
    function automatic int idx_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int IDX_W_DEF = idx_w(WORD_W_DEF);

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-side handshakes plus the bit-serial detector link.
// slave = sequencer side, master = producer/consumer/detector side.
interface seq_det_ctrl_if
    import seq_det_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IDX_W  = idx_w(WORD_W)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    logic              det_x;
    logic              det_clr;
    logic              det_z;

    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;
    logic [IDX_W-1:0]  out_first;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output det_x,
        output det_clr,
        input  det_z,
        output out_valid,
        input  out_ready,
        output out_count,
        output out_hit,
        output out_first
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  det_x,
        input  det_clr,
        output det_z,
        input  out_valid,
        output out_ready,
        input  out_count,
        input  out_hit,
        input  out_first
    );

endinterface

// File: rtl/seq_det_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter.
// o_last flags the slot holding the final bit of the word.
module seq_det_shifter
    import seq_det_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int IDX_W  = idx_w(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_msb,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_last
);

    logic [WORD_W-1:0] r_sr;
    logic [IDX_W-1:0]  r_cnt;

    // Load a fresh word or step one bit toward the MSB output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {r_sr[WORD_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_msb  = r_sr[WORD_W-1];
    assign o_idx  = r_cnt;
    assign o_last = (r_cnt == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit sequencer for a serial pattern detector.
// Feeds each word MSB-first, tallies matches, returns a result.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit CLR_EACH = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_ctrl_if.slave bus
);

    localparam int IDX_W = idx_w(WORD_W);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_det_clr;
    logic              r_out_valid;
    logic              r_hit;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_first;

    logic              w_load;
    logic              w_shift;
    logic              w_msb;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx;

    assign w_load  = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
    assign w_shift = (r_state == S_SHIFT);

    seq_det_shifter #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (bus.in_data),
        .i_shift (w_shift),
        .o_msb   (w_msb),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    // Sequencer FSM; all word-side outputs and tallies are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_det_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_count     <= '0;
            r_first     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_load) begin
                        r_in_ready <= 1'b0;
                        r_count    <= '0;
                        r_hit      <= 1'b0;
                        r_first    <= '0;
                        if (CLR_EACH) begin
                            r_det_clr <= 1'b1;
                            r_state   <= S_CLEAR;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_CLEAR: begin
                    r_det_clr <= 1'b0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bus.det_z) begin
                        r_hit <= 1'b1;
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (!r_hit) begin
                            r_first <= w_idx;
                        end
                    end
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.det_clr   = r_det_clr;
    assign bus.det_x     = w_shift & w_msb;
    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_count;
    assign bus.out_hit   = r_hit;
    assign bus.out_first = r_first;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: three parameter sets, each driving a
// behavioural 1011 overlapping Mealy detector.
module tb_seq_det_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Index 0: CNT_W=4 CLR_EACH=1, 1: CNT_W=1 CLR_EACH=1, 2: CNT_W=4 CLR_EACH=0
    logic       vld[3];
    logic [7:0] dat[3];
    logic       ordy[3];
    logic       nz[3];
    logic       z[3];
    logic       irdy[3];
    logic       ovld[3];
    logic [3:0] cnt[3];
    logic       hit[3];
    logic [2:0] first[3];
    logic       xs[3];
    logic       clrs[3];

    seq_det_ctrl_if #(.WORD_W(8), .CNT_W(4)) ifa ();
    seq_det_ctrl_if #(.WORD_W(8), .CNT_W(1)) ifb ();
    seq_det_ctrl_if #(.WORD_W(8), .CNT_W(4)) ifc ();

    assign ifa.in_valid  = vld[0];
    assign ifa.in_data   = dat[0];
    assign ifa.out_ready = ordy[0];
    assign ifa.det_z     = z[0];
    assign irdy[0]  = ifa.in_ready;
    assign ovld[0]  = ifa.out_valid;
    assign cnt[0]   = 4'(ifa.out_count);
    assign hit[0]   = ifa.out_hit;
    assign first[0] = ifa.out_first;
    assign xs[0]    = ifa.det_x;
    assign clrs[0]  = ifa.det_clr;

    assign ifb.in_valid  = vld[1];
    assign ifb.in_data   = dat[1];
    assign ifb.out_ready = ordy[1];
    assign ifb.det_z     = z[1];
    assign irdy[1]  = ifb.in_ready;
    assign ovld[1]  = ifb.out_valid;
    assign cnt[1]   = 4'(ifb.out_count);
    assign hit[1]   = ifb.out_hit;
    assign first[1] = ifb.out_first;
    assign xs[1]    = ifb.det_x;
    assign clrs[1]  = ifb.det_clr;

    assign ifc.in_valid  = vld[2];
    assign ifc.in_data   = dat[2];
    assign ifc.out_ready = ordy[2];
    assign ifc.det_z     = z[2];
    assign irdy[2]  = ifc.in_ready;
    assign ovld[2]  = ifc.out_valid;
    assign cnt[2]   = 4'(ifc.out_count);
    assign hit[2]   = ifc.out_hit;
    assign first[2] = ifc.out_first;
    assign xs[2]    = ifc.det_x;
    assign clrs[2]  = ifc.det_clr;

    seq_det_ctrl #(.WORD_W(8), .CNT_W(4), .CLR_EACH(1'b1)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa.slave)
    );
    seq_det_ctrl #(.WORD_W(8), .CNT_W(1), .CLR_EACH(1'b1)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb.slave)
    );
    seq_det_ctrl #(.WORD_W(8), .CNT_W(4), .CLR_EACH(1'b0)) dut_c (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    // Detector: advances only while bits are being fed; outside that
    // window z carries random noise the sequencer must ignore.
    for (genvar g = 0; g < 3; g++) begin : g_det
        localparam int CL = (g == 2) ? 0 : 1;
        logic [2:0] hist;
        int         rem;
        logic       win;
        assign win = (rem > 0) && (rem <= 8);
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist <= '0;
                rem  <= 0;
            end else begin
                if (vld[g] && irdy[g]) rem <= 8 + CL;
                else if (rem > 0) rem <= rem - 1;
                if (clrs[g]) hist <= '0;
                else if (win) hist <= {hist[1:0], xs[g]};
            end
        end
        assign z[g] = win ? ((hist == 3'b101) && xs[g]) : nz[g];
    end

    int checks = 0;
    int fails  = 0;
    logic [8:0] xv;
    logic [8:0] cv;
    logic [2:0] tail_c;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: scan the bit string (prior history then word, MSB first)
    function automatic void ref_scan(input logic [2:0] tail,
                                     input logic [7:0] w,
                                     input int cmax,
                                     output int c, output int h,
                                     output int f);
        logic [10:0] s;
        s = {tail, w};
        c = 0;
        f = -1;
        for (int i = 0; i < 8; i++) begin
            if (s[10-i -: 4] == 4'b1011) begin
                if (f < 0) f = i;
                if (c < cmax) c++;
            end
        end
        h = (f >= 0) ? 1 : 0;
        if (f < 0) f = 0;
    endfunction

    task automatic run_word(input int i, input logic [7:0] w,
                            input int ec, input int eh, input int ef,
                            input int elat, input int stall,
                            input bit noise);
        int n;
        int lat;
        vld[i] = 1'b1;
        dat[i] = w;
        n = 0;
        while (!irdy[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("d%0d accept_wait", i), int'(n < 50), 1);
        @(posedge clk); #1;
        vld[i] = 1'b0;
        dat[i] = 8'($urandom);
        lat = 0;
        xv = '0;
        cv = '0;
        while (!ovld[i] && lat < 50) begin
            if (lat < 9) begin
                cv[8-lat] = clrs[i];
                xv[8-lat] = xs[i];
            end
            if (noise) nz[i] = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        nz[i] = 1'b0;
        chk($sformatf("d%0d w%02h latency", i, w), lat, elat);
        chk($sformatf("d%0d w%02h count", i, w), int'(cnt[i]), ec);
        chk($sformatf("d%0d w%02h hit", i, w), int'(hit[i]), eh);
        chk($sformatf("d%0d w%02h first", i, w), int'(first[i]), ef);
        chk($sformatf("d%0d busy_ready", i), int'(irdy[i]), 0);
        for (int s = 0; s < stall; s++) begin
            if (noise) nz[i] = 1'($urandom);
            @(posedge clk); #1;
            chk($sformatf("d%0d stall_hold", i),
                int'(ovld[i] && cnt[i] == 4'(ec) && hit[i] == 1'(eh) &&
                     first[i] == 3'(ef) && !irdy[i] && !xs[i]), 1);
        end
        nz[i] = 1'b0;
        ordy[i] = 1'b1;
        @(posedge clk); #1;
        ordy[i] = 1'b0;
        chk($sformatf("d%0d release_valid", i), int'(ovld[i]), 0);
        chk($sformatf("d%0d release_ready", i), int'(irdy[i]), 1);
    endtask

    typedef struct {
        int         d;
        logic [7:0] w;
        int         c;
        int         h;
        int         f;
        int         lat;
        int         stall;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int h;
        int f;
        logic [7:0] w;

        tbl[0]  = '{0, 8'b1011_0110, 2, 1, 3, 9, 0};
        tbl[1]  = '{0, 8'b0000_0000, 0, 0, 0, 9, 0};
        tbl[2]  = '{0, 8'b1111_1111, 0, 0, 0, 9, 0};
        tbl[3]  = '{0, 8'b0101_1011, 2, 1, 4, 9, 0};
        tbl[4]  = '{0, 8'b1011_1011, 2, 1, 3, 9, 5};
        tbl[5]  = '{1, 8'b1011_0110, 1, 1, 3, 9, 0};
        tbl[6]  = '{1, 8'b1011_1011, 1, 1, 3, 9, 0};
        tbl[7]  = '{2, 8'b0000_0101, 0, 0, 0, 8, 0};
        tbl[8]  = '{2, 8'b1000_0000, 1, 1, 0, 8, 0};
        tbl[9]  = '{2, 8'b1011_0000, 1, 1, 3, 8, 0};
        tbl[10] = '{2, 8'b0110_1101, 1, 1, 5, 8, 0};
        tbl[11] = '{2, 8'b1100_0000, 1, 1, 0, 8, 0};

        for (int i = 0; i < 3; i++) begin
            vld[i]  = 1'b0;
            dat[i]  = 8'h00;
            ordy[i] = 1'b0;
            nz[i]   = 1'b0;
        end
        tail_c = 3'b000;

        // Reset held, then released between edges
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d reset_outputs", i),
                int'({irdy[i], ovld[i], cnt[i], hit[i], first[i],
                      xs[i], clrs[i]} == '0), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_before_edge_ready", int'(irdy[0]), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d ready_after_release", i), int'(irdy[i]), 1);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d idle_outputs", i),
                int'({ovld[i], cnt[i], hit[i], first[i], xs[i], clrs[i]}
                     == '0), 1);
        end

        // Directed vectors
        for (int k = 0; k < 12; k++) begin
            run_word(tbl[k].d, tbl[k].w, tbl[k].c, tbl[k].h, tbl[k].f,
                     tbl[k].lat, tbl[k].stall, 1'b0);
            if (tbl[k].d == 2) tail_c = tbl[k].w[2:0];
            if (k == 0) begin
                chk("det_x_sequence", int'(xv[7:0]), int'(8'b1011_0110));
                chk("det_clr_pulse", int'(cv), int'(9'b1_0000_0000));
            end
        end

        // Randomized words against the bit-string reference
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) begin
                w = 8'($urandom);
                if (i == 2) begin
                    ref_scan(tail_c, w, 15, c, h, f);
                    tail_c = w[2:0];
                end else begin
                    ref_scan(3'b000, w, (i == 1) ? 1 : 15, c, h, f);
                end
                run_word(i, w, c, h, f, (i == 2) ? 8 : 9,
                         $urandom_range(0, 3), 1'b1);
            end
        end

        // Reset pulsed mid-word
        vld[0] = 1'b1;
        dat[0] = 8'b1011_0110;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_shifting", int'(xs[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(ovld[0]), 0);
        chk("abort_ready", int'(irdy[0]), 0);
        chk("abort_det_x", int'(xs[0]), 0);
        chk("abort_det_clr", int'(clrs[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tail_c = 3'b000;
        #1;
        chk("abort_ready_pre_edge", int'(irdy[0]), 0);
        @(posedge clk); #1;
        chk("abort_ready_post_edge", int'(irdy[0]), 1);
        run_word(0, 8'b1011_0110, 2, 1, 3, 9, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Sequencing controller for the serial pattern detector (input x, output z).
- Accepts parallel words over a valid/ready handshake.
- Optionally clears the detector, then shifts each word into it MSB-first, one bit per clock.
- Counts z assertions per word and records the bit index of the first match.
- Returns the per-word result over a second valid/ready handshake.

Sits between the word-level producer/consumer and the bit-serial detector.

Parameters:
WORD_W, 8, bits per input word (>=2).
CNT_W, 4, width of match counter; saturates at 2^CNT_W-1.
CLR_EACH, 1, 1 = pulse detector clear before every word; 0 = detector history carries across word boundaries.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0); all state returns to reset values immediately.
in_valid  input  1  producer has a word.
in_ready  output  1  controller can accept a word.
in_data  input  WORD_W  word to scan, MSB shifted first.
det_x  output  1  serial bit driven to detector x.
det_clr  output  1  synchronous clear pulse to detector state.
det_z  input  1  detector match flag; Mealy, valid in the same cycle as det_x.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_count  output  CNT_W  matches in the word, saturating.
out_hit  output  1  at least one match in the word.
out_first  output  clog2(WORD_W)  bit index (0 = MSB slot) of first match; 0 when out_hit=0.

Behaviour:
- Reset values: in_ready=0, det_x=0, det_clr=0, out_valid=0, out_count=0, out_hit=0, out_first=0; FSM=IDLE; shift register and bit counter = 0.
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&&in_ready at a clock edge latches in_data into the shift register and zeroes count/hit/first/bit counter.
  - Next state: CLEAR if CLR_EACH=1, else SHIFT.
- CLEAR:
  - Exactly one cycle; det_clr=1, det_x=0, in_ready=0.
  - z is ignored this cycle. Next state: SHIFT.
- SHIFT:
  - det_x = shift register MSB; det_clr=0.
  - At each edge: shift left by one; bit counter +1.
  - If det_z=1: out_count += 1 (saturating at max; no wrap); out_hit=1; if it was the first hit, out_first = current bit counter.
  - After bit WORD_W-1 is sampled, next state: DONE.
- DONE:
  - out_valid=1; outputs held stable; det_x=0; in_ready=0.
  - out_valid&&out_ready at an edge leads to IDLE.
  - Back-to-back words therefore see one IDLE cycle between results.
- Latency, from the accept edge to out_valid high: WORD_W+1 cycles (CLR_EACH=1) or WORD_W cycles (CLR_EACH=0).
- Throughput: one word per WORD_W+3 cycles (CLR_EACH=1) or WORD_W+2 cycles (CLR_EACH=0), with out_ready tied high.
- in_data is sampled only at the accept edge; later changes have no effect.
- det_z outside SHIFT is ignored.
- out_valid never drops without out_ready; outputs are stable while stalled.
- Reset asserted mid-word aborts immediately: the partial result is discarded, and the detector sees det_clr=0 and det_x=0.
  - After reset release, the first word with CLR_EACH=0 relies on the detector's own reset.

Decomposition:
- Shared package: FSM state encoding (IDLE/CLEAR/SHIFT/DONE), CNT_W default, and an index-width helper constant, clog2(WORD_W).
- One natural sub-module, seq_det_shifter: parallel-load, MSB-first shift register plus bit counter, with a last-bit flag.
- FSM and counters stay in seq_det_ctrl.

Test Plan:
All scenarios use a 1011 overlapping Mealy detector and WORD_W=8.
1. Reset held low, then released; in_valid=0 -> in_ready=1 on the first edge after release; all outputs stay at reset values.
2. in_data=8'b1011_0110, CLR_EACH=1 -> det_clr high 1 cycle; det_x sequence 1,0,1,1,0,1,1,0; out_valid 9 cycles after accept; out_count=2, out_hit=1, out_first=3.
3. in_data=8'h00 -> out_count=0, out_hit=0, out_first=0.
4. CNT_W=1, in_data=8'b1011_0110 -> out_count saturates at 1; out_hit=1, out_first=3.
5. CLR_EACH=0, words 8'b0000_0101 then 8'b1000_0000 -> first word: count 0. Second word: count 1, first=0 (match spans the word boundary).
6. out_ready low 5 cycles in DONE -> out_valid and results held, in_ready=0. Reset pulsed low during SHIFT -> out_valid=0 and in_ready=0 immediately; in_ready=1 on the first edge after release.
